// File: rtl/layer_sequencer.sv
// Layer sequencer: drives one shared neuron engine over NUM_NEURONS indices,
// requantizes each result and packs it into a flattened activation vector.
module layer_sequencer #(
    parameter int NUM_NEURONS = 10,
    parameter int WIDTH_OUT   = 32,
    parameter int WIDTH_ACT   = 8,
    parameter int SHIFT       = 8,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             layer_go,
    output logic                             neuron_go,
    input  logic                             neuron_done,
    input  logic signed [WIDTH_OUT-1:0]      output_neuron,
    output logic [IDX_W-1:0]                 neuron_idx,
    output logic [WIDTH_ACT*NUM_NEURONS-1:0] layer_out,
    output logic                             layer_done,
    output logic                             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 neuron_idx_q, neuron_idx_d;
    logic [WIDTH_ACT*NUM_NEURONS-1:0] layer_out_q, layer_out_d;
    logic                             neuron_go_q, neuron_go_d;
    logic                             layer_done_q, layer_done_d;
    logic                             busy_q, busy_d;
    logic [WIDTH_ACT-1:0]             act;

    // Negative and zero results clamp to 0; large positives saturate to all-ones.
    function automatic logic [WIDTH_ACT-1:0] requant(input logic signed [WIDTH_OUT-1:0] v);
        logic signed [WIDTH_OUT-1:0] s;
        s = v >>> SHIFT;
        if (v[WIDTH_OUT-1] || (v == '0))
            return '0;
        else if (|s[WIDTH_OUT-1:WIDTH_ACT])
            return '1;
        else
            return s[WIDTH_ACT-1:0];
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d      = state_q;
        neuron_idx_d = neuron_idx_q;
        layer_out_d  = layer_out_q;
        neuron_go_d  = 1'b0;
        layer_done_d = 1'b0;
        busy_d       = busy_q;
        act          = requant(output_neuron);

        // Outputs are computed for the state being entered, so the flops line up with it.
        case (state_q)
            IDLE: begin
                if (layer_go) begin
                    state_d      = ISSUE;
                    neuron_idx_d = '0;
                    neuron_go_d  = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (neuron_done) begin
                    for (int k = 0; k < NUM_NEURONS; k++) begin
                        if (neuron_idx_q == IDX_W'(k))
                            layer_out_d[k*WIDTH_ACT +: WIDTH_ACT] = act;
                    end
                    if (neuron_idx_q == LAST_IDX) begin
                        state_d      = DONE;
                        layer_done_d = 1'b1;
                    end else begin
                        state_d      = ISSUE;
                        neuron_idx_d = neuron_idx_q + 1'b1;
                        neuron_go_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            neuron_idx_q <= '0;
            // NOTE: the activation slots are plain flops, so they can and must be
            // cleared by reset along with the control state.
            layer_out_q  <= '0;
            neuron_go_q  <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            neuron_idx_q <= neuron_idx_d;
            layer_out_q  <= layer_out_d;
            neuron_go_q  <= neuron_go_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
        end
    end

    assign neuron_go  = neuron_go_q;
    assign neuron_idx = neuron_idx_q;
    assign layer_out  = layer_out_q;
    assign layer_done = layer_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a configurable-latency engine stub.
module tb_layer_sequencer;

    localparam int N  = 4;
    localparam int WO = 32;
    localparam int WA = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              layer_go = 1'b0;
    logic              neuron_go;
    logic              neuron_done;
    logic signed [WO-1:0] output_neuron;
    logic [1:0]        neuron_idx;
    logic [WA*N-1:0]   layer_out;
    logic              layer_done;
    logic              busy;

    logic              stub_done = 1'b0;
    logic [WO-1:0]     stub_val = '0;
    logic              inj_done = 1'b0;
    logic [WO-1:0]     inj_val = '0;
    logic signed [WO-1:0] vals [N];
    int                lat = 3;

    int n_tests = 0;
    int n_fail  = 0;
    int go_cnt  = 0;
    int ld_cnt  = 0;

    assign neuron_done   = stub_done | inj_done;
    assign output_neuron = inj_done ? inj_val : stub_val;

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_NEURONS(N), .WIDTH_OUT(WO), .WIDTH_ACT(WA), .SHIFT(8)) dut (
        .clk(clk), .reset(reset), .layer_go(layer_go), .neuron_go(neuron_go),
        .neuron_done(neuron_done), .output_neuron(output_neuron),
        .neuron_idx(neuron_idx), .layer_out(layer_out), .layer_done(layer_done),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine stub: answers each neuron_go after lat extra cycles with vals[idx].
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (neuron_go) begin
                idx = int'(neuron_idx);
                @(posedge clk);
                repeat (lat) @(posedge clk);
                #1 stub_val = vals[idx];
                stub_done = 1'b1;
                @(posedge clk);
                #1 stub_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (neuron_go)  go_cnt++;
        if (layer_done) ld_cnt++;
    end

    task automatic set_vals(input logic [WO-1:0] v0, input logic [WO-1:0] v1,
                            input logic [WO-1:0] v2, input logic [WO-1:0] v3);
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    endtask

    // Runs one pass; cyc is the number of cycles from the layer_go sample edge to layer_done.
    task automatic run_pass(input string tag, input int lat_i, input bit hold_go,
                            input bit spurious, output int cyc);
        bit seen = 1'b0;
        lat = lat_i;
        @(negedge clk);
        layer_go = 1'b1;
        @(posedge clk);
        #1 if (!hold_go) layer_go = 1'b0;
        cyc = 0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            inj_done = 1'b0;
            cyc++;
            if (cyc == 1) begin
                check({tag, "_first_go"},  neuron_go, 1);
                check({tag, "_first_idx"}, neuron_idx, 0);
                check({tag, "_busy"},      busy, 1);
            end
            if (spurious && neuron_go && neuron_idx == 2'd1) begin
                inj_val  = 32'h0000_7F00;
                inj_done = 1'b1;
            end
            if (layer_done) begin
                seen = 1'b1;
                layer_go = 1'b0;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    initial begin
        int cyc, g0, l0;
        logic [WA*N-1:0] snap;
        set_vals(0, 0, 0, 0);

        #12;
        check("rst_busy", busy, 0);
        check("rst_go", neuron_go, 0);
        check("rst_ldone", layer_done, 0);
        check("rst_idx", neuron_idx, 0);
        check("rst_out", layer_out, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("no_go_after_release", go_cnt, 0);

        // Full pass, 3-cycle engine.
        set_vals(32'h100, 32'h200, 32'h300, 32'h400);
        g0 = go_cnt; l0 = ld_cnt;
        run_pass("p1", 3, 1'b0, 1'b0, cyc);
        @(negedge clk);
        check("p1_out", layer_out, 32'h0403_0201);
        check("p1_go_cnt", go_cnt - g0, 4);
        check("p1_ld_cnt", ld_cnt - l0, 1);
        check("p1_idx_hold", neuron_idx, 3);
        check("p1_idle", busy, 0);

        snap = layer_out;
        repeat (5) @(negedge clk);
        check("stable_between", layer_out, snap);

        // Zero-latency engine: 2N+1 cycles.
        set_vals(32'h300, 32'h600, 32'h900, 32'hC00);
        run_pass("p2", 0, 1'b0, 1'b0, cyc);
        check("p2_latency", cyc, 9);
        @(negedge clk);
        check("p2_replace", layer_out, 32'h0C09_0603);

        // Requantization corners.
        set_vals(32'h1234, -32'sd5, 32'h0, 32'h1_0000);
        run_pass("rq1", 1, 1'b0, 1'b0, cyc);
        @(negedge clk);
        check("rq1_out", layer_out, 32'hFF00_0012);
        set_vals(32'hFF, 32'h7FFF_FFFF, 32'h100, 32'h1FF);
        run_pass("rq2", 0, 1'b0, 1'b0, cyc);
        @(negedge clk);
        check("rq2_out", layer_out, 32'h0101_FF00);

        // layer_go held high throughout plus a spurious done during ISSUE.
        set_vals(32'h500, 32'h600, 32'h700, 32'h800);
        g0 = go_cnt; l0 = ld_cnt;
        run_pass("hold", 3, 1'b1, 1'b1, cyc);
        repeat (3) @(negedge clk);
        check("hold_out", layer_out, 32'h0807_0605);
        check("hold_go_cnt", go_cnt - g0, 4);
        check("hold_ld_cnt", ld_cnt - l0, 1);
        check("hold_idle", busy, 0);

        // Spurious done while idle must not touch the slots.
        inj_val = 32'h0000_4400;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("idle_done_ignored", layer_out, 32'h0807_0605);

        // Reset while waiting for neuron 2.
        set_vals(32'h100, 32'h200, 32'h300, 32'h400);
        lat = 3;
        layer_go = 1'b1;
        @(posedge clk);
        #1 layer_go = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(busy && !neuron_go && neuron_idx == 2'd2)) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reached", cyc < 200, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_idx", neuron_idx, 0);
        check("mid_rst_out", layer_out, 0);
        check("mid_rst_go", neuron_go, 0);
        check("mid_rst_ldone", layer_done, 0);
        g0 = go_cnt; l0 = ld_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_rst_no_ld", ld_cnt - l0, 0);
        check("mid_rst_no_go", go_cnt - g0, 0);
        check("mid_rst_out_hold", layer_out, 0);

        g0 = go_cnt;
        run_pass("clean", 3, 1'b0, 1'b0, cyc);
        @(negedge clk);
        check("clean_out", layer_out, 32'h0403_0201);
        check("clean_go_cnt", go_cnt - g0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
